// File: rtl/mux41_pkg.sv
// Shared types and helpers for the 4:1 mux select sequencer.
package mux41_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } state_e;

   function automatic logic [NUM_CH-1:0] onehot_of(input logic [SEL_W-1:0] index);
      onehot_of = NUM_CH'(1) << index;
   endfunction

endpackage

// File: rtl/mux41_rr_pick.sv
// Round-robin picker: first set request scanning last+1, last+2, ... modulo NUM_CH.
module mux41_rr_pick
   import mux41_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  last,
   output logic [SEL_W-1:0]  index,
   output logic              found
);

   logic [SEL_W-1:0] cand;

   // Scan from lowest to highest priority so the highest-priority hit wins.
   always_comb begin
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         cand = last + SEL_W'(k);
         if (req[cand]) begin
            index = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux41_sel_sequencer.sv
// Round-robin s1/s0 select sequencer with valid/ready handoff and post-transfer guard.
// Optional MUX41_SEQ_LOCK_EN adds a lock input that re-grants the same channel back to back.
module mux41_sel_sequencer
   import mux41_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              out_ready,
`ifdef MUX41_SEQ_LOCK_EN
   input  logic              lock,
`endif
   output logic              s0,
   output logic              s1,
   output logic [NUM_CH-1:0] grant,
   output logic              out_valid,
   output logic              busy
);

   localparam int unsigned HOLD_LD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [SEL_W-1:0]    last_q, last_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [SEL_W-1:0]    pick_idx;
   logic                pick_found;
   logic                xfer;
   logic                hold_lock;

   mux41_rr_pick u_pick (
      .req   (req),
      .last  (last_q),
      .index (pick_idx),
      .found (pick_found)
   );

   assign xfer = out_valid_q & out_ready;

`ifdef MUX41_SEQ_LOCK_EN
   assign hold_lock = lock & req[sel_q];
`else
   assign hold_lock = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         last_q      <= SEL_W'(NUM_CH - 1);
         grant_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      grant_d     = grant_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            // Select only moves here, so s1/s0 never glitch mid-transfer.
            if (pick_found) begin
               sel_d       = pick_idx;
               grant_d     = onehot_of(pick_idx);
               out_valid_d = 1'b1;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               out_valid_d = 1'b0;
               if (!hold_lock) begin
                  last_d  = sel_q;
                  grant_d = '0;
                  if (HOLD_CYCLES > 0) begin
                     cnt_d   = CNT_W'(HOLD_LD);
                     state_d = GUARD;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (!out_valid_q) begin
               // One-cycle gap of a locked re-grant is over.
               out_valid_d = 1'b1;
            end
         end
         GUARD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            out_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign s0        = sel_q[0];
   assign s1        = sel_q[1];
   assign grant     = grant_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mux41_sel_sequencer.sv
// Bench: two sequencers (guard 2 and guard 0) against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mux41_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       out_ready;
`ifdef MUX41_SEQ_LOCK_EN
   logic       lock;
`endif

   logic       s0 [2];
   logic       s1 [2];
   logic [3:0] grant [2];
   logic       out_valid [2];
   logic       busy [2];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state per instance: granted channel (-1 none), remaining guard cycles.
   int  m_ch   [2];
   int  m_cool [2];
   int  m_last [2];
   int  m_sel  [2];
   bit  m_valid[2];

   always #5 clk = ~clk;

   mux41_sel_sequencer #(.HOLD_CYCLES(2), .CNT_W(4)) u_dut_h2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_ready (out_ready),
`ifdef MUX41_SEQ_LOCK_EN
      .lock      (lock),
`endif
      .s0        (s0[0]),
      .s1        (s1[0]),
      .grant     (grant[0]),
      .out_valid (out_valid[0]),
      .busy      (busy[0])
   );

   mux41_sel_sequencer #(.HOLD_CYCLES(0), .CNT_W(4)) u_dut_h0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_ready (out_ready),
`ifdef MUX41_SEQ_LOCK_EN
      .lock      (lock),
`endif
      .s0        (s0[1]),
      .s1        (s1[1]),
      .grant     (grant[1]),
      .out_valid (out_valid[1]),
      .busy      (busy[1])
   );

   function automatic int hold_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_next(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ch[d]    = -1;
         m_cool[d]  = 0;
         m_last[d]  = 3;
         m_sel[d]   = 0;
         m_valid[d] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit lk;
      int p;
`ifdef MUX41_SEQ_LOCK_EN
      lk = lock;
`else
      lk = 1'b0;
`endif
      for (int d = 0; d < 2; d++) begin
         if (m_ch[d] >= 0) begin
            if (m_valid[d] && out_ready) begin
               m_valid[d] = 1'b0;
               if (!(lk && req[m_ch[d]])) begin
                  m_last[d] = m_ch[d];
                  m_ch[d]   = -1;
                  m_cool[d] = hold_of(d);
               end
            end else if (!m_valid[d]) begin
               m_valid[d] = 1'b1;
            end
         end else if (m_cool[d] > 0) begin
            m_cool[d]--;
         end else begin
            p = rr_next(m_last[d], req);
            if (p >= 0) begin
               m_ch[d]    = p;
               m_sel[d]   = p;
               m_valid[d] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outs(input string tag);
      logic [7:0] exp, obs;
      logic [3:0] g;
      for (int d = 0; d < 2; d++) begin
         g   = (m_ch[d] >= 0) ? 4'(1 << m_ch[d]) : 4'b0000;
         exp = {((m_ch[d] >= 0) || (m_cool[d] > 0)), m_valid[d], g, 2'(m_sel[d])};
         obs = {busy[d], out_valid[d], grant[d], s1[d], s0[d]};
         check_val($sformatf("%s/h%0d", tag, hold_of(d)), 32'(obs), 32'(exp));
      end
   endtask

   task automatic step(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_outs(tag);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outs(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int seen_ch [$];
   int seen_cyc[$];
   int exp_rot [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n     = 1'b0;
      req       = 4'b0000;
      out_ready = 1'b0;
`ifdef MUX41_SEQ_LOCK_EN
      lock      = 1'b0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      check_outs("reset");
      rst_n = 1'b1;

      // First grant after reset, then hold it and reset mid-GRANT.
      req = 4'b0001;
      step(1, "first_grant");
      step(2, "grant_hold");
      do_reset("reset_mid_grant");

      // Full rotation with everyone requesting.
      req       = 4'b1111;
      out_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         step(1, "rotation");
         if (out_valid[0] === 1'b1) begin
            seen_ch.push_back(int'({s1[0], s0[0]}));
            seen_cyc.push_back(c);
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (i < seen_ch.size()) begin
            check_val($sformatf("rot_order%0d", i), 32'(seen_ch[i]), 32'(exp_rot[i]));
            if (i > 0) check_val($sformatf("rot_period%0d", i),
                                 32'(seen_cyc[i] - seen_cyc[i-1]), 32'd4);
         end else begin
            check_val($sformatf("rot_missing%0d", i), 32'(seen_ch.size()), 32'(i + 1));
         end
      end

      // Backpressure on channel 2 with its request dropping mid-hold.
      req = 4'b0000;
      out_ready = 1'b0;
      step(5, "drain");
      req = 4'b0100;
      step(1, "bp_grant");
      step(1, "bp_hold");
      req = 4'b0000;
      step(3, "bp_hold");
      out_ready = 1'b1;
      step(1, "bp_xfer");
      out_ready = 1'b0;
      step(4, "bp_after");

      // Wrap from last=3: ch2 first, then ch0 before ch1.
      do_reset("reset_wrap");
      req       = 4'b0100;
      step(1, "wrap_ch2");
      out_ready = 1'b1;
      req       = 4'b0011;
      step(12, "wrap_01");

      // Single requester held: guard 0 instance re-grants every 2 cycles.
      req = 4'b0010;
      step(12, "single");

`ifdef MUX41_SEQ_LOCK_EN
      do_reset("reset_lock");
      lock = 1'b1;
      req  = 4'b0010;
      step(10, "lock_regrant");
      req  = 4'b0110;
      step(2, "lock_regrant2");
      lock = 1'b0;
      step(10, "lock_release");
`endif

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         req       = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX41_SEQ_LOCK_EN
         lock      = ($urandom_range(0, 3) == 0);
`endif
         step(1, "random");
         if (c == 200) do_reset("reset_random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux41_sel_sequencer.md
Name: mux41_sel_sequencer

Overview:
- Round-robin select sequencer that sits directly upstream of the 4:1 mux and drives its s0/s1 select lines.
- Arbitrates four channel request lines and holds the chosen select stable while the downstream consumer takes the muxed value through a valid/ready handshake.
- After each transfer it applies a guard interval so the mux output settles before the next switch.

Parameters:
- HOLD_CYCLES, 2, guard cycles after each transfer; select stays stable and out_valid is low; range 0..15.
- CNT_W, 4, width of the guard counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel request; bit i requests mux input in<i>.
- out_ready  input  1  downstream accepts the muxed value.
- s0  output  1  mux select LSB (channel index bit 0).
- s1  output  1  mux select MSB (channel index bit 1).
- grant  output  4  one-hot copy of the current select; zero when not granting.
- out_valid  output  1  muxed value is valid for the granted channel.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release), values take effect immediately:
  - state=IDLE, s0=0, s1=0, grant=0, out_valid=0, busy=0.
  - Round-robin pointer last=3, so channel 0 has first priority.
- Channel encoding: channel i drives {s1,s0}=i. Channel 0 is 00, 1 is 01, 2 is 10, 3 is 11.
- States:
  - IDLE:
    - If req!=0, pick the first set bit scanning last+1, last+2, ... modulo 4 (wraps 3 to 0).
    - Register s1/s0 and grant. Go to GRANT the next cycle.
    - Latency is 1 cycle from req sampled to out_valid=1.
  - GRANT:
    - out_valid=1.
    - Select and grant are frozen even if req drops; a grant is never retracted.
    - Transfer = out_valid & out_ready on a rising edge.
    - On transfer: last <= granted index, out_valid <= 0, grant <= 0.
    - Then go to GUARD if HOLD_CYCLES>0, else IDLE.
  - GUARD:
    - s1/s0 hold the last value, out_valid=0.
    - Counter loads HOLD_CYCLES-1 on entry and decrements each cycle; go to IDLE when it reaches 0.
    - New requests wait; they are evaluated in IDLE.
- s1/s0 change only on the IDLE to GRANT edge. In IDLE they keep their last value to avoid glitches.
- Boundary conditions:
  - All four requesting: strict rotation 0, 1, 2, 3, 0, ...
  - Single requester held high: re-granted each round, with a gap of HOLD_CYCLES+1 cycles between grants.
  - out_ready high on the same cycle GRANT is entered: out_valid is not yet high, so no transfer; the earliest transfer is the first GRANT cycle.
  - Reset mid-GRANT: the transfer is abandoned and last returns to 3.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: MUX41_SEQ_LOCK_EN.
- With the macro defined:
  - Adds input port lock (1 bit).
  - If lock=1 and req[granted] still high at the transfer edge, skip GUARD and stay in GRANT on the same channel. out_valid drops for exactly 1 cycle, then reasserts.
  - last is not advanced while locked.
- Without the macro: no lock port, behaviour exactly as above.

Decomposition:
- Shared package mux41_pkg contains:
  - state typedef {IDLE, GRANT, GUARD}, 2 bits.
  - NUM_CH=4 and SEL_W=2.
  - Function onehot_of(index).
- One natural sub-module, mux41_rr_pick: combinational req[3:0] plus last[1:0] in, index[1:0] plus found out. It is the only round-robin logic.
- The FSM, guard counter and output registers stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-run, checked with no clock edge -> outputs all 0; after release, req=4'b0001 -> {s1,s0}=00, grant=0001, out_valid=1 one cycle later.
- Rotation: req=4'b1111, out_ready=1, HOLD_CYCLES=2 -> grants 0,1,2,3,0 in order, each out_valid pulse separated by 3 idle/guard cycles.
- Backpressure: grant ch2, out_ready=0 for 5 cycles, drop req[2] in cycle 2 -> out_valid and {s1,s0}=10 held all 5 cycles; one transfer when out_ready=1.
- Wrap: last=3, req=4'b0100 -> ch2; then req=4'b0011 -> ch0 before ch1.
- Guard: HOLD_CYCLES=0 with req=4'b0010 held -> out_valid period of 2 cycles; select never toggles.
- Lock (MUX41_SEQ_LOCK_EN): lock=1, req[1] held -> ch1 regranted with a 1-cycle out_valid gap; lock=0 -> rotation resumes at ch2.
